// File: rtl/mips_pkg.sv
// Shared fetch-path types and sizing helpers.
// Pure declarations: no latency, no flow control.
// Used by the fetch queue and its FIFO.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] inst;
        logic [WORD_W-1:0] pc;
    } inst_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {inst, pc} entries with flush.
// Latency: a pushed entry is readable at head the cycle after the push.
// Backpressure: none internally; the caller's credit scheme prevents overflow.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  inst_entry_t      push_dat,
    input  logic             pop,
    input  logic             flush,
    output inst_entry_t      head,
    output logic [CNT_W-1:0] count
);

    inst_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, issues imem word reads, buffers words for decode; FETCH_STATS_EN adds stall/drop counters.
// Latency: instruction visible on inst_* the cycle after its memory response.
// Backpressure: requests gated by FIFO credits (count + outstanding < DEPTH); redirect flushes and drops in-flight words.
module inst_fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [29:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_drops
`endif
);

    localparam int              CNT_W   = cnt_w(DEPTH);
    localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [31:0]      redirect_base;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic             run_q;
    logic             accept;
    logic             rsp_fire;
    logic             discard;
    logic             keep;
    logic             pop;
    inst_entry_t      head;
    inst_entry_t      push_dat;

    assign imem_req_valid = reset && run_q && !redirect_valid &&
                            (({1'b0, count} + {1'b0, outstanding}) < CREDITS);
    assign imem_addr      = fetch_pc[31:2];
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding can only be a leftover from before reset.
    assign rsp_fire        = imem_rsp_valid && (outstanding != '0);
    assign discard         = rsp_fire && (redirect_valid || (drop_cnt != '0));
    assign keep            = rsp_fire && !discard;
    assign outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(rsp_fire);
    assign redirect_base   = redirect_pc & 32'hFFFF_FFFC;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_valid ? head.inst : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;
    assign push_dat   = '{inst: imem_rsp_data, pc: rsp_pc};

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_q       <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run_q       <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                rsp_pc   <= redirect_base;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_STEP;
                if (keep)   rsp_pc   <= rsp_pc + PC_STEP;
                if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (keep),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .count    (count)
    );

    overflow_chk: assert property (@(posedge clock) disable iff (!reset)
                                   !(rsp_fire && (count == CNT_W'(DEPTH))));

`ifdef FETCH_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_stall_cycles <= '0;
            stat_drops        <= '0;
        end else begin
            if (!inst_valid && !redirect_valid && (stat_stall_cycles != 32'hFFFF_FFFF))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            if (discard && (stat_drops != 32'hFFFF_FFFF))
                stat_drops <= stat_drops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order, variable-latency memory model.
module tb_inst_fetch_queue;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [29:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_drops;
`endif

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_STATS_EN
        ,
        .stat_stall_cycles (stat_stall_cycles),
        .stat_drops        (stat_drops)
`endif
    );

    typedef struct {
        logic [29:0] a;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] dq[$];
    logic [31:0] dd[$];
    int          cyc     = 0;
    int          lat     = 1;
    int          acc_cnt = 0;
    int          errors  = 0;
    int          checks  = 0;
    int          n;

    function automatic logic [31:0] md(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hDEAD_BEEF;
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: accepted requests are answered in order, lat cycles later, one per cycle.
    always @(negedge clock) begin
        if (reset && imem_req_valid && imem_req_ready) begin
            mq.push_back('{a: imem_addr, due: cyc + lat});
            acc_cnt++;
        end
        if (reset && inst_valid && inst_ready && !redirect_valid) begin
            dq.push_back(inst_pc);
            dd.push_back(inst);
        end
    end

    always @(posedge clock) begin
        #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = md(mq[0].a);
            void'(mq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit clr);
        reset = 1'b0;
        redirect_valid = 1'b0;
        if (clr) mq.delete();
        repeat (2) tick();
        reset = 1'b1;
        dq.delete();
        dd.delete();
        acc_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // 1: reset state, startup latency, steady one-per-cycle stream
        repeat (2) tick();
        @(negedge clock);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        lat = 1;
        do_reset(1);
        @(negedge clock);
        check("c0_req_valid", imem_req_valid, 0);
        check("c0_inst_valid", inst_valid, 0);
        tick();
        @(negedge clock);
        check("c1_req_valid", imem_req_valid, 1);
        check("c1_addr", 32'(imem_addr), 0);
        tick();
        @(negedge clock);
        check("c2_inst_valid", inst_valid, 0);
        tick();
        @(negedge clock);
        check("c3_inst_valid", inst_valid, 1);
        check("c3_inst_pc", inst_pc, 0);
        repeat (8) tick();
        check("t1_count", 32'(dq.size()), 8);
        for (int i = 0; i < 8 && i < dq.size(); i++) begin
            check("t1_pc", dq[i], 32'(i * 4));
            check("t1_data", dd[i], md(30'(i)));
        end

        // 2: decode stalled -> exactly 4 requests, then drain in order
        inst_ready = 1'b0;
        do_reset(1);
        repeat (10) tick();
        @(negedge clock);
        check("t2_accepts", 32'(acc_cnt), 4);
        check("t2_req_valid", imem_req_valid, 0);
        check("t2_inst_valid", inst_valid, 1);
        check("t2_head_pc", inst_pc, 0);
        tick();
        inst_ready = 1'b1;
        repeat (8) tick();
        check("t2_min_count", 32'(dq.size() >= 5), 1);
        for (int i = 0; i < 5 && i < dq.size(); i++)
            check("t2_pc", dq[i], 32'(i * 4));

        // 3: redirect with three requests outstanding
        lat = 10;
        do_reset(1);
        repeat (4) tick();
        imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clock);
        check("t3_req_valid_redir", imem_req_valid, 0);
        check("t3_outstanding", 32'(acc_cnt), 3);
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 80 && dq.size() < 2; i++) tick();
        check("t3_delivered", 32'(dq.size() >= 2), 1);
        if (dq.size() >= 2) begin
            check("t3_first_pc", dq[0], 32'h0000_0100);
            check("t3_first_data", dd[0], md(30'h40));
            check("t3_second_pc", dq[1], 32'h0000_0104);
        end
`ifdef FETCH_STATS_EN
        check("t3_stat_drops", stat_drops, 3);
`endif

        // 4: redirect coincides with a response while decode is popping
        lat = 1;
        do_reset(1);
        repeat (6) tick();
        n = dq.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clock);
        check("t4_req_valid_redir", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clock);
        check("t4_flushed", inst_valid, 0);
        repeat (6) tick();
        check("t4_delivered", 32'(dq.size() > n + 1), 1);
        if (dq.size() > n + 1) begin
            check("t4_first_pc", dq[n], 32'h0000_0200);
            check("t4_second_pc", dq[n + 1], 32'h0000_0204);
        end

        // 5: PC wraps past the top of the address space
        n = dq.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        check("t5_delivered", 32'(dq.size() > n + 2), 1);
        if (dq.size() > n + 2) begin
            check("t5_pc0", dq[n], 32'hFFFF_FFF8);
            check("t5_pc1", dq[n + 1], 32'hFFFF_FFFC);
            check("t5_pc2", dq[n + 2], 32'h0000_0000);
            check("t5_data2", dd[n + 2], md(30'h0));
        end

        // 6: reset with FIFO full; stale responses must be ignored
        inst_ready = 1'b0;
        do_reset(1);
        repeat (10) tick();
        @(negedge clock);
        check("t6_full_valid", inst_valid, 1);
        check("t6_full_req", imem_req_valid, 0);
        tick();
        reset      = 1'b0;
        inst_ready = 1'b1;
        @(negedge clock);
        mq.delete();
        mq.push_back('{a: 30'h10, due: cyc + 1});
        mq.push_back('{a: 30'h11, due: cyc + 3});
        tick();
        @(negedge clock);
        check("t6_rst_inst_valid", inst_valid, 0);
        check("t6_rst_req_valid", imem_req_valid, 0);
        check("t6_rst_addr", 32'(imem_addr), 0);
        check("t6_rst_inst", inst, 0);
        check("t6_rst_inst_pc", inst_pc, 0);
        tick();
        reset = 1'b1;
        dq.delete();
        dd.delete();
        repeat (8) tick();
        check("t6_delivered", 32'(dq.size() >= 2), 1);
        if (dq.size() >= 2) begin
            check("t6_first_pc", dq[0], 32'h0);
            check("t6_first_data", dd[0], md(30'h0));
            check("t6_second_pc", dq[1], 32'h4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
